// File: rtl/sequenciador_instrucao.sv
// Instruction sequencer: buffers 9-bit instruction words in a small FIFO and
// steps each one through four control-unit cycles (count 00..11).
module sequenciador_instrucao #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [8:0] instr_in,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       halt,
    input  logic       abort,
    output logic [8:0] ir,
    output logic [1:0] count,
    output logic       busy,
    output logic       done,
    output logic [3:0] level
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t      r_state;
    logic [8:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]  r_level;
    logic [8:0]  r_ir;
    logic [1:0]  r_count;
    logic        r_done;

    state_t      w_state_nxt;
    logic [1:0]  w_count_nxt;
    logic        w_done_nxt;
    logic        w_pop;
    logic        w_push;
    logic        w_ready;
    logic        w_not_empty;

    // Pop decisions only look at the registered level, so a word pushed this
    // edge cannot be popped before the next one.
    assign w_ready     = (r_level != 4'(DEPTH));
    assign w_not_empty = (r_level != 4'd0);
    assign w_push      = instr_valid & w_ready & ~abort;

    // Next-state, step counter, pop request and done pulse
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_count_nxt = 2'b00;
                    if (w_not_empty && !halt) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (halt) begin
                        w_count_nxt = r_count;
                    end else if (r_count != 2'b11) begin
                        w_count_nxt = r_count + 2'b01;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_count_nxt = 2'b00;
                        if (w_not_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = 2'b00;
                end
            endcase
        end
    end

    // Control state, instruction register, step counter and done pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_ir    <= 9'd0;
            r_count <= 2'b00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            if (w_pop) begin
                r_ir <= r_mem[r_rd_ptr];
            end else begin
                r_ir <= r_ir;
            end
        end
    end

    // FIFO pointers and occupancy; abort empties the buffer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 4'd0;
        end else if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 4'd1;
                2'b01:   r_level <= r_level - 4'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 9'd0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= instr_in;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    assign instr_ready = w_ready;
    assign ir          = r_ir;
    assign count       = r_count;
    assign busy        = (r_state == ST_EXEC);
    assign done        = r_done;
    assign level       = r_level;

endmodule

// File: tb/tb_sequenciador_instrucao.sv
// Self-checking bench for sequenciador_instrucao: directed scenarios plus
// random traffic, all compared each cycle against a queue-based model.
module tb_sequenciador_instrucao;

    localparam int DEPTH = 4;

    logic       clock;
    logic       resetn;
    logic [8:0] instr_in;
    logic       instr_valid;
    logic       instr_ready;
    logic       halt;
    logic       abort;
    logic [8:0] ir;
    logic [1:0] count;
    logic       busy;
    logic       done;
    logic [3:0] level;

    int n_tests;
    int n_fail;

    // model: pending words, current word, step index, executing flag, done pulse
    logic [8:0] m_q[$];
    logic [8:0] m_ir;
    int         m_step;
    bit         m_busy;
    bit         m_done;

    sequenciador_instrucao #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halt        (halt),
        .abort       (abort),
        .ir          (ir),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .level       (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ir   = 9'd0;
        m_step = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    // One clock edge of the sequencer behaviour, from the rules directly
    task automatic model_edge(input logic v, input logic [8:0] d, input logic h, input logic a);
        int  held;
        bit  take;
        held = m_q.size();
        take = v && (held < DEPTH) && !a;
        if (a) begin
            m_q.delete();
            m_busy = 1'b0;
            m_step = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (held > 0 && !h) begin
                    m_ir   = m_q.pop_front();
                    m_step = 0;
                    m_busy = 1'b1;
                end
            end else if (!h) begin
                if (m_step < 3) begin
                    m_step = m_step + 1;
                end else begin
                    m_done = 1'b1;
                    m_step = 0;
                    if (held > 0) m_ir = m_q.pop_front();
                    else          m_busy = 1'b0;
                end
            end
            if (take) m_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        check_value("ir",          32'(ir),          32'(m_ir));
        check_value("count",       32'(count),       32'(m_step));
        check_value("busy",        32'(busy),        32'(m_busy));
        check_value("done",        32'(done),        32'(m_done));
        check_value("level",       32'(level),       32'(m_q.size()));
        check_value("instr_ready", 32'(instr_ready), 32'(m_q.size() < DEPTH));
    endtask

    task automatic run_cycle(input logic v, input logic [8:0] d, input logic h, input logic a);
        instr_valid = v;
        instr_in    = d;
        halt        = h;
        abort       = a;
        model_edge(v, d, h, a);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 9'd0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_ir"},    32'(ir),          32'h0);
        check_value({tag, "_count"}, 32'(count),       32'h0);
        check_value({tag, "_busy"},  32'(busy),        32'h0);
        check_value({tag, "_done"},  32'(done),        32'h0);
        check_value({tag, "_level"}, 32'(level),       32'h0);
        check_value({tag, "_ready"}, 32'(instr_ready), 32'h1);
    endtask

    initial begin
        int guard;
        n_tests     = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        instr_in    = 9'd0;
        instr_valid = 1'b0;
        halt        = 1'b0;
        abort       = 1'b0;
        model_reset();

        #3;
        check_reset_values("rst");
        @(posedge clock);
        @(posedge clock);
        #1;
        check_reset_values("rst_hold");
        resetn = 1'b1;

        // single instruction
        run_cycle(1'b1, 9'h0D1, 1'b0, 1'b0);
        idle_cycles(7);
        check_value("single_ir", 32'(ir), 32'h0D1);

        // back-to-back
        run_cycle(1'b1, 9'h011, 1'b0, 1'b0);
        run_cycle(1'b1, 9'h122, 1'b0, 1'b0);
        run_cycle(1'b1, 9'h1F3, 1'b0, 1'b0);
        idle_cycles(14);

        // full while halted, then drain in order
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 9'(9'h040 + i), 1'b1, 1'b0);
        check_value("full_level", 32'(level), 32'(DEPTH));
        check_value("full_ready", 32'(instr_ready), 32'h0);
        idle_cycles(20);

        // halt mid-instruction at count=10
        run_cycle(1'b1, 9'h155, 1'b0, 1'b0);
        guard = 0;
        while (!(m_busy && m_step == 2) && guard < 10) begin
            run_cycle(1'b0, 9'd0, 1'b0, 1'b0);
            guard++;
        end
        check_value("halt_reach_timeout", 32'(guard < 10), 32'h1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 9'd0, 1'b1, 1'b0);
        check_value("halt_count", 32'(count), 32'h2);
        idle_cycles(6);

        // abort with level=3, count=01
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 9'(9'h0A0 + i), 1'b1, 1'b0);
        run_cycle(1'b1, 9'h0A3, 1'b0, 1'b0);
        run_cycle(1'b0, 9'd0, 1'b0, 1'b0);
        check_value("pre_abort_level", 32'(level), 32'h3);
        check_value("pre_abort_count", 32'(count), 32'h1);
        run_cycle(1'b1, 9'h1AB, 1'b1, 1'b1);
        check_value("abort_level", 32'(level), 32'h0);
        check_value("abort_busy",  32'(busy),  32'h0);
        idle_cycles(6);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                      1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) == 0));
        end
        idle_cycles(30);

        // asynchronous reset in the middle of an instruction
        run_cycle(1'b1, 9'h0F0, 1'b0, 1'b0);
        run_cycle(1'b1, 9'h0F1, 1'b0, 1'b0);
        run_cycle(1'b0, 9'd0, 1'b0, 1'b0);
        check_value("pre_reset_busy", 32'(busy), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clock);
        #1;
        check_reset_values("async_rst_edge");
        resetn = 1'b1;
        run_cycle(1'b1, 9'h0D1, 1'b0, 1'b0);
        idle_cycles(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sequenciador_instrucao.md
SEQUENCIADOR_INSTRUCAO -- requirements
Module: sequenciador_instrucao

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction FIFO entries; legal values are 2, 4 or 8.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_in  input  9  instruction word {op[8:6], rega[5:3], regb[2:0]}.
REQ-005 SHALL have port instr_valid  input  1  instr_in is valid this cycle.
REQ-006 SHALL have port instr_ready  output  1  FIFO can accept a word; equals not full.
REQ-007 SHALL have port halt  input  1  freezes stepping and pops while 1.
REQ-008 SHALL have port abort  input  1  synchronous flush of FIFO and current instruction.
REQ-009 SHALL have port ir  output  9  instruction register feeding the control unit's in.
REQ-010 SHALL have port count  output  2  step counter feeding the control unit's count.
REQ-011 SHALL have port busy  output  1  1 while state is EXEC.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last step of an instruction.
REQ-013 SHALL have port level  output  4  number of words held in the FIFO, 0..DEPTH.

Function
REQ-014 SHALL accept a word on a rising edge when instr_valid=1, instr_ready=1 and abort=0.
REQ-015 SHALL buffer words in a DEPTH-entry FIFO with read/write pointers wrapping modulo DEPTH.
REQ-016 SHALL provide no bypass: a word pushed at edge N is poppable at edge N+1 at the earliest.
REQ-017 SHALL keep level unchanged on a simultaneous push and pop.
REQ-018 SHALL never push when full (instr_ready=0) and never pop when empty.
REQ-019 SHALL implement two states, IDLE and EXEC; busy=1 only in EXEC.
REQ-020 SHALL, in IDLE with level>0, halt=0, abort=0: pop head into ir, set count=00, enter EXEC.
REQ-021 SHALL, in IDLE otherwise, hold ir, keep count=00.
REQ-022 SHALL, in EXEC with halt=1, hold count, ir and state unchanged.
REQ-023 SHALL, in EXEC with halt=0 and count<11, increment count by 1.
REQ-024 SHALL, in EXEC with halt=0 and count=11, assert done=1 for the next cycle only.
REQ-025 SHALL, on that same edge, pop the next word into ir with count=00 and stay in EXEC if level>0 (no bubble), else enter IDLE with count=00 and ir held.
REQ-026 SHALL give a 4-cycle steady-state throughput per instruction; single-instruction latency from push edge N: ir loaded at N+1, done high in cycle after edge N+5.
REQ-027 SHALL, on abort=1 at an edge, empty the FIFO (level=0), go IDLE, set count=00, keep done=0; abort overrides halt and push.
REQ-028 SHALL keep done=0 in every cycle not covered by REQ-024.

Reset
REQ-029 SHALL, while resetn=0, force state=IDLE, ir=9'b0, count=00, busy=0, done=0, level=0, pointers=0, instr_ready=1.
REQ-030 SHALL resume normal operation from the first rising clock edge after resetn rises, discarding any instruction in flight.

Verification
REQ-031 SHALL check single instruction: push 9'h0D1 at edge N -> ir=9'h0D1 at N+1, count 00,01,10,11, done=1 one cycle, then IDLE, busy=0.
REQ-032 SHALL check back-to-back: push 3 words -> count runs 00..11 three times with no idle cycle, done pulses 4 cycles apart, level returns to 0.
REQ-033 SHALL check full: with DEPTH=4 and halt=1, push 5 words -> level=4, instr_ready=0, 5th word not accepted; release halt -> 4 instructions execute in push order.
REQ-034 SHALL check halt mid-instruction: halt=1 at count=10 for 3 cycles -> count stays 10, done=0, resumes at 11 afterwards.
REQ-035 SHALL check abort: level=3, count=01, assert abort one cycle -> level=0, busy=0, count=00, no done pulse.
REQ-036 SHALL check async reset: drop resetn mid-EXEC between edges -> outputs take reset values immediately, without a clock edge.
